// File: rtl/register_access_controller_pkg.sv
`default_nettype none
// ============================================================================
// register_access_controller_pkg : types shared by the controller and board
// Revision: 1.0
// ============================================================================
package register_access_controller_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    A_SEL  = 2'd0,
    D_SEL  = 2'd1,
    A_ZERO = 2'd2,
    A_OFF  = 2'd3
  } register_board_a_mode_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ALU = 4'h1,
    OP_MOV = 4'h2,
    OP_LDI = 4'h3,
    OP_CLR = 4'h4,
    OP_INC = 4'h5
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_READ     = 2'd1,
    S_WRITE    = 2'd2,
    S_IMM_WAIT = 2'd3
  } state_e;

  typedef struct packed {
    opcode_e          op;
    logic             legal;
    logic [SEL_W-1:0] rd;
    logic [SEL_W-1:0] ra;
    logic [SEL_W-1:0] rb;
  } decode_t;

endpackage
`default_nettype wire

// File: rtl/register_access_decode.sv
`default_nettype none
// ============================================================================
// register_access_decode : splits an instruction word into opcode and selects
// Revision: 1.0
// ============================================================================
module register_access_decode
  import register_access_controller_pkg::*;
(
  input  logic [DATA_W-1:0] instr_i,
  output decode_t           dec_o
);

  always_comb begin
    dec_o.rd    = instr_i[11:8];
    dec_o.ra    = instr_i[7:4];
    dec_o.rb    = instr_i[3:0];
    dec_o.legal = (instr_i[15:12] <= 4'h5);
    // Undefined opcodes are folded onto NOP so op always holds a named value
    dec_o.op    = dec_o.legal ? opcode_e'(instr_i[15:12]) : OP_NOP;
  end

endmodule
`default_nettype wire

// File: rtl/register_access_controller.sv
`default_nettype none
// ============================================================================
// register_access_controller : sequences register board reads/writes per word
// Revision: 1.0
// ============================================================================
module register_access_controller
  import register_access_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic [DATA_W-1:0]      instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [DATA_W-1:0]      a_in,
  input  logic [DATA_W-1:0]      alu_result,
  output register_board_a_mode_t a_mode,
  output logic                   n_b_en,
  output logic [SEL_W-1:0]       a_sel,
  output logic [SEL_W-1:0]       b_sel,
  output logic [SEL_W-1:0]       d_sel,
  output logic [DATA_W-1:0]      d,
  output logic                   n_load,
  output logic                   illegal,
  output logic [DATA_W-1:0]      retired_count
);

  state_e                 state_q, state_d;
  opcode_e                op_q, op_d;
  logic [SEL_W-1:0]       rd_q, rd_d;
  logic [DATA_W-1:0]      capture_q, capture_d;
  logic                   ready_q, ready_d;
  register_board_a_mode_t a_mode_q, a_mode_d;
  logic                   n_b_en_q, n_b_en_d;
  logic [SEL_W-1:0]       a_sel_q, a_sel_d;
  logic [SEL_W-1:0]       b_sel_q, b_sel_d;
  logic [SEL_W-1:0]       d_sel_q, d_sel_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   n_load_q, n_load_d;
  logic                   illegal_q, illegal_d;
  logic [DATA_W-1:0]      count_q, count_d;

  decode_t                dec;
  logic                   accept;
  logic [SEL_W-1:0]       wr_rd;
  logic [DATA_W-1:0]      wr_val;

  register_access_decode u_decode (
    .instr_i (instr),
    .dec_o   (dec)
  );

  assign accept = instr_valid & ready_q;

  // Ready resets low so it first rises on the edge after reset release
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NOP;
      rd_q      <= '0;
      capture_q <= '0;
      ready_q   <= 1'b0;
      a_mode_q  <= A_OFF;
      n_b_en_q  <= 1'b1;
      a_sel_q   <= '0;
      b_sel_q   <= '0;
      d_sel_q   <= '0;
      wdata_q   <= '0;
      n_load_q  <= 1'b1;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      capture_q <= capture_d;
      ready_q   <= ready_d;
      a_mode_q  <= a_mode_d;
      n_b_en_q  <= n_b_en_d;
      a_sel_q   <= a_sel_d;
      b_sel_q   <= b_sel_d;
      d_sel_q   <= d_sel_d;
      wdata_q   <= wdata_d;
      n_load_q  <= n_load_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && dec.legal) begin
          case (dec.op)
            OP_ALU, OP_MOV, OP_INC: state_d = S_READ;
            OP_CLR:                 state_d = S_WRITE;
            OP_LDI:                 state_d = S_IMM_WAIT;
            default:                state_d = S_IDLE;
          endcase
        end
      end
      S_READ:     state_d = S_WRITE;
      S_WRITE:    state_d = S_IDLE;
      S_IMM_WAIT: if (accept) state_d = S_WRITE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output registers are loaded with the values belonging to state_d
  always_comb begin
    ready_d   = (state_d == S_IDLE) || (state_d == S_IMM_WAIT);
    a_mode_d  = A_OFF;
    n_b_en_d  = 1'b1;
    a_sel_d   = '0;
    b_sel_d   = '0;
    d_sel_d   = '0;
    wdata_d   = '0;
    n_load_d  = 1'b1;
    illegal_d = 1'b0;
    count_d   = count_q;
    op_d      = op_q;
    rd_d      = rd_q;
    capture_d = capture_q;
    wr_rd     = rd_q;
    wr_val    = capture_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = dec.op;
          rd_d      = dec.rd;
          illegal_d = ~dec.legal;
          if (dec.legal && dec.op == OP_NOP) count_d = count_q + 16'd1;
          wr_rd     = dec.rd;
          wr_val    = '0;
        end
      end
      S_READ: begin
        case (op_q)
          OP_ALU:  wr_val = alu_result;
          OP_MOV:  wr_val = a_in;
          default: wr_val = a_in + 16'd1;
        endcase
      end
      S_WRITE:    count_d = count_q + 16'd1;
      S_IMM_WAIT: wr_val = instr;
      default:    wr_val = capture_q;
    endcase

    if (state_d == S_READ) begin
      case (dec.op)
        OP_ALU: begin
          a_mode_d = A_SEL;
          a_sel_d  = dec.ra;
          n_b_en_d = 1'b0;
          b_sel_d  = dec.rb;
        end
        OP_MOV: begin
          a_mode_d = A_SEL;
          a_sel_d  = dec.ra;
        end
        default: begin
          a_mode_d = D_SEL;
          d_sel_d  = dec.rd;
        end
      endcase
    end

    // r0 is not writable: the cycle still happens but the strobe stays high
    if (state_d == S_WRITE) begin
      capture_d = wr_val;
      d_sel_d   = wr_rd;
      wdata_d   = wr_val;
      n_load_d  = (wr_rd == 4'd0);
    end
  end

  assign instr_ready   = ready_q;
  assign a_mode        = a_mode_q;
  assign n_b_en        = n_b_en_q;
  assign a_sel         = a_sel_q;
  assign b_sel         = b_sel_q;
  assign d_sel         = d_sel_q;
  assign d             = wdata_q;
  assign n_load        = n_load_q;
  assign illegal       = illegal_q;
  assign retired_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_register_access_controller.sv
`default_nettype none
// ============================================================================
// tb_register_access_controller : scoreboard bench with a transaction model
// Revision: 1.0
// ============================================================================
module tb_register_access_controller;
  import register_access_controller_pkg::*;

  logic                   clk = 1'b0;
  logic                   n_reset = 1'b0;
  logic [15:0]            instr = '0;
  logic                   instr_valid = 1'b0;
  logic                   instr_ready;
  logic [15:0]            a_in = '0;
  logic [15:0]            alu_result = '0;
  register_board_a_mode_t a_mode;
  logic                   n_b_en;
  logic [3:0]             a_sel, b_sel, d_sel;
  logic [15:0]            d;
  logic                   n_load;
  logic                   illegal;
  logic [15:0]            retired_count;

  register_access_controller dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .a_in          (a_in),
    .alu_result    (alu_result),
    .a_mode        (a_mode),
    .n_b_en        (n_b_en),
    .a_sel         (a_sel),
    .b_sel         (b_sel),
    .d_sel         (d_sel),
    .d             (d),
    .n_load        (n_load),
    .illegal       (illegal),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic [1:0]  a_mode;
    logic        n_b_en;
    logic [3:0]  a_sel;
    logic [3:0]  b_sel;
    logic [3:0]  d_sel;
    logic [15:0] d;
    logic        n_load;
    logic        illegal;
    logic [15:0] count;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  int          cyc = 0;
  logic [15:0] m_count = '0;

  function automatic logic [15:0] r16();
    return 16'($urandom);
  endfunction

  function automatic logic rv();
    return 1'($urandom);
  endfunction

  function automatic exp_t idle_e(input logic ill);
    exp_t e;
    e = '0;
    e.ready   = 1'b1;
    e.a_mode  = A_OFF;
    e.n_b_en  = 1'b1;
    e.n_load  = 1'b1;
    e.illegal = ill;
    e.count   = m_count;
    return e;
  endfunction

  function automatic exp_t busy_e();
    exp_t e;
    e = idle_e(1'b0);
    e.ready = 1'b0;
    return e;
  endfunction

  function automatic exp_t write_e(input logic [3:0] rd, input logic [15:0] val);
    exp_t e;
    e = busy_e();
    e.d_sel  = rd;
    e.d      = val;
    e.n_load = (rd == 4'd0);
    return e;
  endfunction

  // One clock cycle: present inputs, record what must appear after the edge
  task automatic drive(input logic v, input logic [15:0] w, input logic [15:0] a,
                       input logic [15:0] alu, input exp_t e);
    instr_valid = v;
    instr       = w;
    a_in        = a;
    alu_result  = alu;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    drive(1'b0, r16(), r16(), r16(), idle_e(1'b0));
  endtask

  task automatic issue(input logic [15:0] w, input logic [15:0] a,
                       input logic [15:0] alu, input logic [15:0] imm, input int gap);
    logic [3:0]  op, rd, ra, rb;
    logic [15:0] val;
    exp_t        e;
    op = w[15:12]; rd = w[11:8]; ra = w[7:4]; rb = w[3:0];
    case (op)
      4'h0: begin
        m_count = m_count + 16'd1;
        drive(1'b1, w, r16(), r16(), idle_e(1'b0));
      end
      4'h1, 4'h2, 4'h5: begin
        e = busy_e();
        if (op == 4'h5) begin
          e.a_mode = D_SEL;
          e.d_sel  = rd;
        end else begin
          e.a_mode = A_SEL;
          e.a_sel  = ra;
          if (op == 4'h1) begin
            e.n_b_en = 1'b0;
            e.b_sel  = rb;
          end
        end
        drive(1'b1, w, r16(), r16(), e);
        val = (op == 4'h1) ? alu : (op == 4'h2) ? a : a + 16'd1;
        drive(rv(), r16(), a, alu, write_e(rd, val));
        m_count = m_count + 16'd1;
        drive(rv(), r16(), r16(), r16(), idle_e(1'b0));
      end
      4'h3: begin
        drive(1'b1, w, r16(), r16(), idle_e(1'b0));
        for (int i = 0; i < gap; i++) drive(1'b0, r16(), r16(), r16(), idle_e(1'b0));
        drive(1'b1, imm, r16(), r16(), write_e(rd, imm));
        m_count = m_count + 16'd1;
        drive(rv(), r16(), r16(), r16(), idle_e(1'b0));
      end
      4'h4: begin
        drive(1'b1, w, r16(), r16(), write_e(rd, 16'h0000));
        m_count = m_count + 16'd1;
        drive(rv(), r16(), r16(), r16(), idle_e(1'b0));
      end
      default: drive(1'b1, w, r16(), r16(), idle_e(1'b1));
    endcase
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered and left at a falling edge; reset effects are checked directly
  task automatic do_reset();
    n_reset = 1'b0;
    mon_en  = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk("rst_n_load", {15'd0, n_load}, 16'd1);
    chk("rst_a_mode", {14'd0, a_mode}, {14'd0, A_OFF});
    chk("rst_n_b_en", {15'd0, n_b_en}, 16'd1);
    chk("rst_count", retired_count, 16'd0);
    chk("rst_illegal", {15'd0, illegal}, 16'd0);
    chk("rst_sel_d", {4'd0, a_sel, b_sel, d_sel} | d, 16'd0);
    m_count = '0;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    mon_en  = 1'b1;
    idle_cycle();
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (mon_en) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard cyc=%0d: got output with no expected entry", cyc);
      end else begin
        e = q.pop_front();
        if (instr_ready !== e.ready || a_mode !== e.a_mode || n_b_en !== e.n_b_en ||
            a_sel !== e.a_sel || b_sel !== e.b_sel || d_sel !== e.d_sel || d !== e.d ||
            n_load !== e.n_load || illegal !== e.illegal || retired_count !== e.count) begin
          failures++;
          $display("FAIL cycle cyc=%0d got rdy=%b mode=%0d nb=%b as=%h bs=%h ds=%h d=%h nl=%b ill=%b cnt=%h expected rdy=%b mode=%0d nb=%b as=%h bs=%h ds=%h d=%h nl=%b ill=%b cnt=%h",
                   cyc, instr_ready, a_mode, n_b_en, a_sel, b_sel, d_sel, d, n_load, illegal, retired_count,
                   e.ready, e.a_mode, e.n_b_en, e.a_sel, e.b_sel, e.d_sel, e.d, e.n_load, e.illegal, e.count);
        end
      end
      cyc++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    do_reset();

    issue(16'h1312, r16(), 16'hBEEF, 16'h0000, 0);
    idle_cycle();
    issue(16'h5500, 16'hFFFF, r16(), 16'h0000, 0);
    issue(16'h3700, r16(), r16(), 16'hA5A5, 4);
    issue(16'h4000, r16(), r16(), 16'h0000, 0);
    issue(16'hF123, r16(), r16(), 16'h0000, 0);
    idle_cycle();
    issue(16'h0000, r16(), r16(), 16'h0000, 0);
    issue(16'h2640, 16'h1234, r16(), 16'h0000, 0);

    // Reset landing in the middle of a WRITE cycle
    drive(1'b1, 16'h1312, r16(), r16(),
          '{ready:1'b0, a_mode:A_SEL, n_b_en:1'b0, a_sel:4'h1, b_sel:4'h2,
             d_sel:4'h0, d:16'h0, n_load:1'b1, illegal:1'b0, count:m_count});
    drive(1'b0, r16(), r16(), 16'h7777, write_e(4'h3, 16'h7777));
    do_reset();
    issue(16'h2940, 16'h4321, r16(), 16'h0000, 0);

    // Reset while an LDI waits for its immediate: the next word is a NOP
    drive(1'b1, 16'h3900, r16(), r16(), idle_e(1'b0));
    do_reset();
    issue(16'h0000, r16(), r16(), 16'h0000, 0);

    for (int n = 0; n < 400; n++) begin
      issue(r16(), r16(), r16(), r16(), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    idle_cycle();
    mon_en = 1'b0;
    chk("queue_drained", 16'(q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_access_controller.md
REGISTER_ACCESS_CONTROLLER -- requirements
Module: register_access_controller

Interface
REQ-001 SHALL have the following ports, one clock and one asynchronous active-low reset; ports are listed clock and reset first:
clk  input  1  single clock, all state updates on rising edge
n_reset  input  1  asynchronous active-low reset
instr  input  16  instruction or immediate word: [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb
instr_valid  input  1  instr word offered
instr_ready  output  1  controller accepts word; transfer when valid && ready at rising clk
a_in  input  16  register board A bus readback
alu_result  input  16  external ALU output, a function of a_in and b_in
a_mode  output  2  register_board_a_mode_t: A_SEL, D_SEL, A_ZERO or A_OFF
n_b_en  output  1  active-low B output enable
a_sel  output  4  register board A select
b_sel  output  4  register board B select
d_sel  output  4  register board destination select
d  output  16  write data
n_load  output  1  active-low write strobe
illegal  output  1  one-cycle pulse on an undefined opcode
retired_count  output  16  count of completed instructions, wraps

REQ-002 SHALL define these opcodes: 0x0 NOP, 0x1 ALU (rd=alu(ra,rb)), 0x2 MOV (rd=ra), 0x3 LDI (rd=next word), 0x4 CLR (rd=0), 0x5 INC (rd=rd+1); 0x6-0xF are undefined.

Function
REQ-003 SHALL implement FSM states IDLE, READ, WRITE and IMM_WAIT, with every output registered.
REQ-004 SHALL drive instr_ready=1 only in IDLE and IMM_WAIT.
REQ-005 SHALL drive idle defaults in IDLE and IMM_WAIT: a_mode=A_OFF, n_b_en=1, n_load=1, selects=0, d=0.
REQ-006 ALU: accept -> READ, driving a_mode=A_SEL, a_sel=ra, n_b_en=0, b_sel=rb; SHALL capture alu_result at the end of READ.
REQ-006a ALU, continued: -> WRITE, driving d_sel=rd, d=capture, n_load=0; -> IDLE. Accept-to-ready latency is 3 cycles.
REQ-007 MOV: same as ALU except n_b_en stays 1 in READ and the captured value is a_in.
REQ-008 INC: READ drives a_mode=D_SEL, d_sel=rd; SHALL capture a_in+1 modulo 2^16, so 0xFFFF becomes 0x0000; then WRITE as REQ-006a.
REQ-009 CLR: accept -> WRITE with d=0x0000 and no READ cycle.
REQ-010 LDI: accept -> IMM_WAIT; on the next handshake the whole 16-bit word is the immediate -> WRITE with d=immediate.
REQ-010a LDI, continued: IMM_WAIT SHALL persist indefinitely while instr_valid=0.
REQ-011 NOP: accept -> stay IDLE with no board activity; it is retired on the accept cycle.
REQ-012 Undefined opcode: accept -> stay IDLE, illegal=1 for exactly one cycle; it SHALL NOT be retired.
REQ-013 rd=0 on a write SHALL keep n_load=1 in WRITE (write discarded); the cycle sequence is unchanged and the instruction is retired.
REQ-014 retired_count SHALL increment by 1 in the cycle after WRITE completes (or after a NOP accept); 0xFFFF wraps to 0x0000.
REQ-015 In WRITE, n_load, d_sel and d SHALL be stable for the full cycle so the board latches them on the closing rising edge.
REQ-016 Input words are ignored while instr_ready=0; instr_valid high without a handshake SHALL have no effect.

Reset
REQ-017 n_reset low SHALL immediately force: state=IDLE, outputs to REQ-005 defaults, illegal=0, retired_count=0, capture register=0.
REQ-018 Reset asserted during READ, WRITE or IMM_WAIT SHALL abort the instruction: no write strobe completes, no retire, and a pending LDI is discarded.
REQ-019 After deassertion, instr_ready=1 from the first rising edge.

Structure
REQ-020 Shared package SHALL hold register_board_a_mode_t (moved from the register board so both ends share it), the opcode enum and the FSM state enum.
REQ-021 SHALL contain one combinational sub-module, register_access_decode, mapping instr to opcode class, operand selects and legality.

Verification
REQ-022 Bench SHALL cover these directed scenarios:
- Reset, then ALU 0x1312 with alu_result=0xBEEF -> READ: a_sel=1, b_sel=2, n_b_en=0; WRITE: d_sel=3, d=0xBEEF, n_load=0; retired_count=1.
- INC 0x5500 with a_in=0xFFFF -> READ a_mode=D_SEL, d_sel=5; WRITE d=0x0000.
- LDI 0x3700, valid low 4 cycles, then 0xA5A5 -> ready stays 1 in IMM_WAIT; WRITE d_sel=7, d=0xA5A5.
- CLR 0x4000 (rd=0) -> one WRITE cycle with n_load=1; retired_count increments.
- Opcode 0xF123 -> illegal pulse for 1 cycle, no board activity, retired_count unchanged.
- Reset asserted mid-WRITE -> n_load high immediately, count=0; the next instruction is accepted normally.
